// File: rtl/inst_mem_resp.sv
// Instruction memory with a fixed-latency fetch response path.
// One request is in flight at a time; the array is preloaded through a
// dedicated write port and is not cleared by reset.
module inst_mem_resp #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i_mem,
    input  logic        InstEnable_i_mem,
    input  logic        flush_i_mem,
    input  logic        wr_en_i_mem,
    input  logic [31:0] wr_addr_i_mem,
    input  logic [31:0] wr_data_i_mem,
    output logic [31:0] mem_o_inst,
    output logic [31:0] mem_o_pc,
    output logic        mem_o_valid,
    output logic        mem_o_busy,
    output logic [1:0]  mem_o_exc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [31:0]     req_pc;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            load_resp;
    logic [31:0]     rd_pc;
    logic [AW-1:0]   rd_idx;
    logic            rd_mis;
    logic            rd_oor;
    logic [31:0]     rd_data;

    logic [AW-1:0]   wr_idx;
    logic            wr_ok;
    logic            unused_wr_lsb;

    // Next-state, counter and response-load decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_resp = 1'b0;
        accept    = ((state == IDLE) || (state == RESP)) &&
                    InstEnable_i_mem && !flush_i_mem;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (flush_i_mem) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read address: with single-cycle latency the response is loaded on the
    // accepting edge itself, so the live pc is used instead of the captured one.
    always_comb begin
        rd_pc   = (state == WAIT) ? req_pc : pc_i_mem;
        rd_idx  = rd_pc[AW+1:2];
        rd_mis  = |rd_pc[1:0];
        rd_oor  = |rd_pc[31:AW+2];
        rd_data = mem[rd_idx];
    end

    // Preload write decode; byte-lane bits of the address are ignored.
    always_comb begin
        wr_idx        = wr_addr_i_mem[AW+1:2];
        wr_ok         = ~|wr_addr_i_mem[31:AW+2];
        unused_wr_lsb = ^wr_addr_i_mem[1:0];
    end

    // State, counter, request capture and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_pc     <= '0;
            mem_o_inst <= '0;
            mem_o_pc   <= '0;
            mem_o_exc  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_pc <= pc_i_mem;
            end
            if (load_resp) begin
                mem_o_inst <= (rd_mis || rd_oor) ? '0 : rd_data;
                mem_o_pc   <= rd_pc;
                mem_o_exc  <= {rd_oor, rd_mis};
            end
        end
    end

    // Array write port; the read above sees the pre-write word on a shared edge.
    always_ff @(posedge clk) begin
        if (wr_en_i_mem && wr_ok) begin
            mem[wr_idx] <= wr_data_i_mem;
        end
    end

    // Strobes derived from the state; a flush suppresses a presenting response.
    always_comb begin
        mem_o_valid = (state == RESP) && !flush_i_mem;
        mem_o_busy  = (state == WAIT);
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp: three instances (latency 1, 2, 3) share
// one set of inputs; each check targets the instance under discussion.
module tb_inst_mem_resp;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        en;
    logic        fl;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;

    logic [31:0] inst1, pco1, inst2, pco2, inst3, pco3;
    logic        val1, bsy1, val2, bsy2, val3, bsy3;
    logic [1:0]  exc1, exc2, exc3;

    int n_cmp = 0;
    int n_bad = 0;

    inst_mem_resp #(.DEPTH(16), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .pc_i_mem(pc), .InstEnable_i_mem(en),
        .flush_i_mem(fl), .wr_en_i_mem(we), .wr_addr_i_mem(wa),
        .wr_data_i_mem(wd), .mem_o_inst(inst1), .mem_o_pc(pco1),
        .mem_o_valid(val1), .mem_o_busy(bsy1), .mem_o_exc(exc1));

    inst_mem_resp #(.DEPTH(16), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .pc_i_mem(pc), .InstEnable_i_mem(en),
        .flush_i_mem(fl), .wr_en_i_mem(we), .wr_addr_i_mem(wa),
        .wr_data_i_mem(wd), .mem_o_inst(inst2), .mem_o_pc(pco2),
        .mem_o_valid(val2), .mem_o_busy(bsy2), .mem_o_exc(exc2));

    inst_mem_resp #(.DEPTH(16), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .pc_i_mem(pc), .InstEnable_i_mem(en),
        .flush_i_mem(fl), .wr_en_i_mem(we), .wr_addr_i_mem(wa),
        .wr_data_i_mem(wd), .mem_o_inst(inst3), .mem_o_pc(pco3),
        .mem_o_valid(val3), .mem_o_busy(bsy3), .mem_o_exc(exc3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        fl;
        logic [31:0] pc;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        ev;
        logic        eb;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [1:0]  ee;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic e, input logic f, input logic [31:0] p,
                                input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic v, input logic b, input logic [31:0] i,
                                input logic [31:0] q, input logic [1:0] x);
        vec_t r;
        r.en = e; r.fl = f; r.pc = p; r.we = w; r.wa = a; r.wd = d;
        r.ev = v; r.eb = b; r.ei = i; r.ep = q; r.ee = x;
        return r;
    endfunction

    // Preload image: word i holds A000_000i except word 3 (a NOP encoding).
    function automatic logic [31:0] img(input int unsigned i);
        return (i == 3) ? 32'h0000_0013 : (32'hA000_0000 + 32'(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        en = 1'b0; fl = 1'b0; we = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0; pc = '0; en = 1'b0; fl = 1'b0; we = 1'b0; wa = '0; wd = '0;

        // Tables for the latency-2 instance: one row per cycle.
        tbl[0]  = mk(1, 0, 32'h0C, 0, 0, 0,          0, 0, 32'h0,         32'h0,  2'b00);
        tbl[1]  = mk(0, 0, 32'h00, 0, 0, 0,          0, 1, 32'h0,         32'h0,  2'b00);
        tbl[2]  = mk(0, 0, 32'h00, 0, 0, 0,          1, 0, 32'h13,        32'h0C, 2'b00);
        tbl[3]  = mk(0, 0, 32'h00, 0, 0, 0,          0, 0, 32'h13,        32'h0C, 2'b00);
        tbl[4]  = mk(1, 0, 32'h00, 0, 0, 0,          0, 0, 32'h13,        32'h0C, 2'b00);
        tbl[5]  = mk(1, 0, 32'h04, 0, 0, 0,          0, 1, 32'h13,        32'h0C, 2'b00);
        tbl[6]  = mk(1, 0, 32'h04, 0, 0, 0,          1, 0, 32'hA000_0000, 32'h00, 2'b00);
        tbl[7]  = mk(0, 0, 32'h00, 0, 0, 0,          0, 1, 32'hA000_0000, 32'h00, 2'b00);
        tbl[8]  = mk(0, 0, 32'h00, 0, 0, 0,          1, 0, 32'hA000_0001, 32'h04, 2'b00);
        tbl[9]  = mk(1, 0, 32'h06, 0, 0, 0,          0, 0, 32'hA000_0001, 32'h04, 2'b00);
        tbl[10] = mk(1, 0, 32'h40, 0, 0, 0,          0, 1, 32'hA000_0001, 32'h04, 2'b00);
        tbl[11] = mk(1, 0, 32'h40, 0, 0, 0,          1, 0, 32'h0,         32'h06, 2'b01);
        tbl[12] = mk(0, 0, 32'h00, 0, 0, 0,          0, 1, 32'h0,         32'h06, 2'b01);
        tbl[13] = mk(1, 0, 32'h42, 0, 0, 0,          1, 0, 32'h0,         32'h40, 2'b10);
        tbl[14] = mk(0, 0, 32'h00, 0, 0, 0,          0, 1, 32'h0,         32'h40, 2'b10);
        tbl[15] = mk(0, 1, 32'h00, 0, 0, 0,          0, 0, 32'h0,         32'h42, 2'b11);
        tbl[16] = mk(1, 1, 32'h08, 0, 0, 0,          0, 0, 32'h0,         32'h42, 2'b11);
        tbl[17] = mk(0, 0, 32'h00, 0, 0, 0,          0, 0, 32'h0,         32'h42, 2'b11);
        tbl[18] = mk(1, 0, 32'h14, 0, 0, 0,          0, 0, 32'h0,         32'h42, 2'b11);
        tbl[19] = mk(0, 0, 32'h00, 1, 32'h17, 32'h55, 0, 1, 32'h0,        32'h42, 2'b11);
        tbl[20] = mk(0, 0, 32'h00, 0, 0, 0,          1, 0, 32'hA000_0005, 32'h14, 2'b00);
        tbl[21] = mk(1, 0, 32'h14, 0, 0, 0,          0, 0, 32'hA000_0005, 32'h14, 2'b00);
        tbl[22] = mk(0, 0, 32'h00, 0, 0, 0,          0, 1, 32'hA000_0005, 32'h14, 2'b00);
        tbl[23] = mk(0, 0, 32'h00, 0, 0, 0,          1, 0, 32'h55,        32'h14, 2'b00);
        tbl[24] = mk(0, 0, 32'h00, 0, 0, 0,          0, 0, 32'h55,        32'h14, 2'b00);

        // Reset values.
        #1;
        chk("rst_inst",  inst2, 32'h0);
        chk("rst_pc",    pco2,  32'h0);
        chk("rst_exc",   32'(exc2), 32'h0);
        chk("rst_valid", 32'(val2), 32'h0);
        chk("rst_busy",  32'(bsy2), 32'h0);
        #12 rst = 1'b1;
        tick();

        // Preload, then an out-of-range write that must not alias word 0.
        for (int unsigned i = 0; i < 16; i++) begin
            we = 1'b1; wa = 32'(i) * 4; wd = img(i);
            tick();
        end
        wa = 32'h40; wd = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;

        for (int unsigned i = 0; i < 25; i++) begin
            en = tbl[i].en; fl = tbl[i].fl; pc = tbl[i].pc;
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(val2),  32'(tbl[i].ev));
            chk($sformatf("v%0d_busy", i),  32'(bsy2),  32'(tbl[i].eb));
            chk($sformatf("v%0d_inst", i),  inst2,      tbl[i].ei);
            chk($sformatf("v%0d_pc", i),    pco2,       tbl[i].ep);
            chk($sformatf("v%0d_exc", i),   32'(exc2),  32'(tbl[i].ee));
            tick();
        end
        idle(4);

        // Latency 3: normal response timing.
        en = 1'b1; pc = 32'h08;
        tick();
        en = 1'b0;
        chk("l3_busy_a", 32'(bsy3), 32'h1);
        chk("l3_val_a",  32'(val3), 32'h0);
        tick();
        chk("l3_busy_b", 32'(bsy3), 32'h1);
        tick();
        chk("l3_val_c",  32'(val3), 32'h1);
        chk("l3_busy_c", 32'(bsy3), 32'h0);
        chk("l3_inst_c", inst3, img(2));
        chk("l3_pc_c",   pco3,  32'h08);
        tick();
        chk("l3_val_d",  32'(val3), 32'h0);
        idle(3);

        // Latency 3: flush one cycle after acceptance drops the request.
        en = 1'b1; pc = 32'h08;
        tick();
        en = 1'b0; fl = 1'b1;
        #1;
        chk("l3f_busy_w", 32'(bsy3), 32'h1);
        tick();
        fl = 1'b0;
        chk("l3f_busy_n", 32'(bsy3), 32'h0);
        for (int unsigned i = 0; i < 4; i++) begin
            chk($sformatf("l3f_noval%0d", i), 32'(val3), 32'h0);
            tick();
        end
        idle(3);

        // Latency 1: a request every cycle streams back one per cycle.
        for (int unsigned k = 0; k < 9; k++) begin
            en = (k < 8); pc = 32'(k) * 4;
            #1;
            chk($sformatf("l1_busy%0d", k), 32'(bsy1), 32'h0);
            if (k > 0) begin
                chk($sformatf("l1_val%0d", k),  32'(val1), 32'h1);
                chk($sformatf("l1_inst%0d", k), inst1, (k == 6) ? 32'h55 : img(k - 1));
                chk($sformatf("l1_pc%0d", k),   pco1,  32'(k - 1) * 4);
            end
            tick();
        end
        chk("l1_val_end", 32'(val1), 32'h0);
        idle(4);

        // Latency 2: reset asserted mid-WAIT clears everything at once.
        en = 1'b1; pc = 32'h0C;
        tick();
        en = 1'b0;
        chk("rw_busy_pre", 32'(bsy2), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rw_inst",  inst2, 32'h0);
        chk("rw_pc",    pco2,  32'h0);
        chk("rw_exc",   32'(exc2), 32'h0);
        chk("rw_valid", 32'(val2), 32'h0);
        chk("rw_busy",  32'(bsy2), 32'h0);
        tick();
        #3 rst = 1'b1;
        tick();
        for (int unsigned i = 0; i < 4; i++) begin
            chk($sformatf("rw_noval%0d", i), 32'(val2 | bsy2), 32'h0);
            tick();
        end
        en = 1'b1; pc = 32'h0C;
        tick();
        en = 1'b0;
        tick();
        chk("rw_re_val",  32'(val2), 32'h1);
        chk("rw_re_inst", inst2, 32'h13);
        chk("rw_re_pc",   pco2,  32'h0C);
        chk("rw_re_exc",  32'(exc2), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
